// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: next-PC selection for j/jal/jr/branches,
// halt/continue handshake with a synchronised operator button, and fault trapping.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           MEM_LAST   = 150
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] jr_target,
    input  logic                  continue_btn,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  exec_enable,
    output logic                  link_write,
    output logic [ADDR_WIDTH-1:0] link_addr,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           retired_count
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    localparam logic [5:0] OP_J    = 6'b010111;
    localparam logic [5:0] OP_JAL  = 6'b011010;
    localparam logic [5:0] OP_JR   = 6'b011011;
    localparam logic [5:0] OP_HALT = 6'b011101;
    localparam logic [5:0] OP_BEQ  = 6'b001001;
    localparam logic [5:0] OP_BLT  = 6'b011100;
    localparam logic [5:0] OP_BGT  = 6'b011110;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_retired;
    logic [1:0]            r_sync;
    logic                  r_sync_prev;

    logic [5:0]            w_opcode;
    logic [PW-1:0]         w_pc_inc;
    logic [PW-1:0]         w_target;
    logic                  w_encode_bad;
    logic                  w_target_fault;
    logic                  w_cont_edge;

    // Next-PC selection; the extra top bit lets pc+1 wrap show up as out of range.
    always_comb begin
        w_opcode     = instr[31:26];
        w_pc_inc     = PW'(r_pc) + PW'(1);
        w_target     = w_pc_inc;
        w_encode_bad = 1'b0;
        case (w_opcode)
            OP_J, OP_JAL: begin
                w_target     = PW'(instr[ADDR_WIDTH-1:0]);
                w_encode_bad = |instr[25:ADDR_WIDTH];
            end
            OP_JR: begin
                w_target = PW'(jr_target);
            end
            OP_BEQ, OP_BLT, OP_BGT: begin
                if (branch_taken) begin
                    w_target     = PW'(instr[ADDR_WIDTH-1:0]);
                    w_encode_bad = |instr[15:ADDR_WIDTH];
                end
            end
            default: begin
            end
        endcase
        w_target_fault = w_encode_bad | (w_target > PW'(MEM_LAST));
        w_cont_edge    = r_sync[1] & ~r_sync_prev;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_retired   <= '0;
            r_sync      <= 2'b11;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync      <= {r_sync[0], continue_btn};
            r_sync_prev <= r_sync[1];
            if (r_state == S_RUN && r_retired != 32'hFFFF_FFFF) begin
                r_retired <= r_retired + 32'd1;
            end
            case (r_state)
                S_RUN: begin
                    if (w_target_fault) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_pc <= w_target[ADDR_WIDTH-1:0];
                        if (w_opcode == OP_HALT) begin
                            r_state <= S_HALTED;
                        end
                    end
                end
                S_HALTED: begin
                    if (w_cont_edge) begin
                        r_state <= S_RUN;
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    assign pc            = r_pc;
    assign retired_count = r_retired;
    assign exec_enable   = (r_state == S_RUN);
    assign halted        = (r_state == S_HALTED);
    assign fault         = (r_state == S_FAULT);
    assign link_addr     = w_pc_inc[ADDR_WIDTH-1:0];
    assign link_write    = exec_enable & (w_opcode == OP_JAL);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for next-PC/link behaviour plus
// hand sequences for halt/continue timing, faults and reset overrides.
module tb_fetch_unit;

    localparam logic [31:0] ADDI = 32'h2C00_0000;
    localparam logic [31:0] HALT = 32'h7400_0000;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        branch_taken;
    logic [9:0]  jr_target;
    logic        continue_btn;
    logic [9:0]  pc;
    logic        exec_enable;
    logic        link_write;
    logic [9:0]  link_addr;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .continue_btn (continue_btn),
        .pc           (pc),
        .exec_enable  (exec_enable),
        .link_write   (link_write),
        .link_addr    (link_addr),
        .halted       (halted),
        .fault        (fault),
        .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ins;
        logic        br;
        logic [9:0]  jr;
        logic [9:0]  la;
        logic        lw;
        logic [9:0]  pc_next;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [31:0] ins);
        instr        = ins;
        branch_taken = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(ADDI);
        cyc(ADDI);
        reset = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic [9:0] e_pc, input logic e_ex,
                             input logic e_h, input logic e_f);
        chk({name, " pc"}, 32'(pc), 32'(e_pc));
        chk({name, " exec_enable"}, 32'(exec_enable), 32'(e_ex));
        chk({name, " halted"}, 32'(halted), 32'(e_h));
        chk({name, " fault"}, 32'(fault), 32'(e_f));
    endtask

    task automatic fault_case(input string name, input logic [31:0] ins, input logic br,
                              input logic [9:0] e_pc);
        instr        = ins;
        branch_taken = br;
        @(posedge clock);
        #1;
        chk_state(name, e_pc, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset        = 1'b1;
        instr        = ADDI;
        branch_taken = 1'b0;
        jr_target    = '0;
        continue_btn = 1'b0;

        vecs[0]  = '{32'h5C00_006B, 1'b0, 10'd0,   10'd1,   1'b0, 10'd107};
        vecs[1]  = '{32'h6800_001B, 1'b0, 10'd0,   10'd108, 1'b1, 10'd27};
        vecs[2]  = '{ADDI,          1'b0, 10'd0,   10'd28,  1'b0, 10'd28};
        vecs[3]  = '{32'h6C00_0000, 1'b0, 10'd108, 10'd29,  1'b0, 10'd108};
        vecs[4]  = '{32'h5C00_000C, 1'b0, 10'd0,   10'd109, 1'b0, 10'd12};
        vecs[5]  = '{32'h7000_0018, 1'b1, 10'd0,   10'd13,  1'b0, 10'd24};
        vecs[6]  = '{32'h5C00_000C, 1'b0, 10'd0,   10'd25,  1'b0, 10'd12};
        vecs[7]  = '{32'h7000_0018, 1'b0, 10'd0,   10'd13,  1'b0, 10'd13};
        vecs[8]  = '{32'h7800_0096, 1'b1, 10'd0,   10'd14,  1'b0, 10'd150};
        vecs[9]  = '{32'h2400_0005, 1'b1, 10'd0,   10'd151, 1'b0, 10'd5};
        vecs[10] = '{32'h6800_0000, 1'b0, 10'd0,   10'd6,   1'b1, 10'd0};
        vecs[11] = '{32'h6C00_0000, 1'b0, 10'd150, 10'd1,   1'b0, 10'd150};
        vecs[12] = '{32'h6C00_0000, 1'b0, 10'd3,   10'd151, 1'b0, 10'd3};
        vecs[13] = '{ADDI,          1'b1, 10'd0,   10'd4,   1'b0, 10'd4};
        vecs[14] = '{32'h24FF_0007, 1'b1, 10'd0,   10'd5,   1'b0, 10'd7};

        do_reset();
        chk_state("reset", 10'd0, 1'b1, 1'b0, 1'b0);
        chk("reset retired", retired_count, 32'd0);

        // Sequential run
        for (int i = 1; i <= 5; i++) begin
            cyc(ADDI);
            chk("seq pc", 32'(pc), 32'(i));
            chk("seq exec_enable", 32'(exec_enable), 32'd1);
        end
        chk("seq retired", retired_count, 32'd5);

        // Jump, step, halt, idle
        cyc(32'h5C00_0052);
        chk("j82 pc", 32'(pc), 32'd82);
        cyc(ADDI);
        chk("step pc", 32'(pc), 32'd83);
        cyc(HALT);
        chk_state("halt", 10'd84, 1'b0, 1'b1, 1'b0);
        chk("halt retired", retired_count, 32'd8);
        for (int i = 0; i < 20; i++) cyc(ADDI);
        chk_state("idle", 10'd84, 1'b0, 1'b1, 1'b0);
        chk("idle retired", retired_count, 32'd8);

        // One-clock pulse: resume on the third clock after the rise
        continue_btn = 1'b1;
        cyc(ADDI);
        continue_btn = 1'b0;
        chk("pulse clk1 exec", 32'(exec_enable), 32'd0);
        cyc(ADDI);
        chk("pulse clk2 exec", 32'(exec_enable), 32'd0);
        cyc(ADDI);
        chk_state("pulse clk3", 10'd84, 1'b1, 1'b0, 1'b0);
        cyc(ADDI);
        chk("resume pc", 32'(pc), 32'd85);
        chk("resume retired", retired_count, 32'd9);

        // Held button gives exactly one resume
        cyc(HALT);
        chk_state("halt2", 10'd86, 1'b0, 1'b1, 1'b0);
        continue_btn = 1'b1;
        cyc(ADDI);
        cyc(ADDI);
        chk("held clk2 exec", 32'(exec_enable), 32'd0);
        cyc(ADDI);
        chk_state("held clk3", 10'd86, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(ADDI);
        chk("held run pc", 32'(pc), 32'd93);
        cyc(HALT);
        chk_state("halt3", 10'd94, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(ADDI);
        chk_state("held no retrigger", 10'd94, 1'b0, 1'b1, 1'b0);
        continue_btn = 1'b0;
        for (int i = 0; i < 3; i++) cyc(ADDI);
        chk_state("released", 10'd94, 1'b0, 1'b1, 1'b0);

        // Resume, then an edge during RUN must not be remembered
        continue_btn = 1'b1;
        cyc(ADDI);
        continue_btn = 1'b0;
        cyc(ADDI);
        cyc(ADDI);
        chk_state("resume3", 10'd94, 1'b1, 1'b0, 1'b0);
        continue_btn = 1'b1;
        cyc(ADDI);
        continue_btn = 1'b0;
        cyc(ADDI);
        cyc(ADDI);
        cyc(ADDI);
        chk("run-edge pc", 32'(pc), 32'd98);
        cyc(HALT);
        for (int i = 0; i < 5; i++) cyc(ADDI);
        chk_state("run-edge ignored", 10'd99, 1'b0, 1'b1, 1'b0);
        chk("run-edge retired", retired_count, 32'd23);

        // Table of control-flow vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            instr        = vecs[i].ins;
            branch_taken = vecs[i].br;
            jr_target    = vecs[i].jr;
            #1;
            chk($sformatf("vec%0d link_write", i), 32'(link_write), 32'(vecs[i].lw));
            chk($sformatf("vec%0d link_addr", i), 32'(link_addr), 32'(vecs[i].la));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d pc", i), 32'(pc), 32'(vecs[i].pc_next));
            chk($sformatf("vec%0d exec", i), 32'(exec_enable), 32'd1);
        end
        chk("table retired", retired_count, 32'd15);

        // Out-of-range jump faults; button ignored in FAULT
        instr = 32'h5C00_00C8;
        #1;
        chk("fault pre link_write", 32'(link_write), 32'd0);
        @(posedge clock);
        #1;
        chk_state("j200 fault", 10'd7, 1'b0, 1'b0, 1'b1);
        chk("fault retired", retired_count, 32'd16);
        chk("fault link_write", 32'(link_write), 32'd0);
        continue_btn = 1'b1;
        cyc(ADDI);
        continue_btn = 1'b0;
        for (int i = 0; i < 5; i++) cyc(ADDI);
        chk_state("fault sticky", 10'd7, 1'b0, 1'b0, 1'b1);
        chk("fault retired hold", retired_count, 32'd16);

        // Reset from FAULT with button held
        continue_btn = 1'b1;
        do_reset();
        chk_state("reset from fault", 10'd0, 1'b1, 1'b0, 1'b0);
        chk("reset from fault retired", retired_count, 32'd0);
        cyc(HALT);
        for (int i = 0; i < 5; i++) cyc(ADDI);
        chk_state("held after fault reset", 10'd1, 1'b0, 1'b1, 1'b0);

        // Reset from HALTED with button held
        do_reset();
        chk_state("reset from halted", 10'd0, 1'b1, 1'b0, 1'b0);
        cyc(HALT);
        chk("halt link_write", 32'(link_write), 32'd0);
        for (int i = 0; i < 5; i++) cyc(ADDI);
        chk_state("held after halt reset", 10'd1, 1'b0, 1'b1, 1'b0);
        continue_btn = 1'b0;
        cyc(ADDI);
        cyc(ADDI);
        continue_btn = 1'b1;
        cyc(ADDI);
        continue_btn = 1'b0;
        cyc(ADDI);
        chk("repress clk2 exec", 32'(exec_enable), 32'd0);
        cyc(ADDI);
        chk_state("repress resume", 10'd1, 1'b1, 1'b0, 1'b0);

        // Fault boundaries: pc+1 past MEM_LAST, bad j encoding, bad branch encoding
        cyc(32'h5C00_0096);
        chk("j150 pc", 32'(pc), 32'd150);
        fault_case("inc past last", ADDI, 1'b0, 10'd150);
        do_reset();
        fault_case("j high bits", 32'h5C00_0400, 1'b0, 10'd0);
        do_reset();
        cyc(ADDI);
        fault_case("blt high bits", 32'h7000_0405, 1'b1, 10'd1);
        do_reset();
        cyc(ADDI);
        instr        = 32'h7000_0405;
        branch_taken = 1'b0;
        @(posedge clock);
        #1;
        chk_state("blt not taken", 10'd2, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch sequencer sitting directly upstream of the instruction memory.
- Drives the 10-bit instruction address, receives the 32-bit instruction word back, and computes the next PC.
- Handles jump, jal, jr, taken branches and the halt/continue handshake with the operator button.
- Gates execution in the single-cycle datapath through exec_enable.

Parameters:
- ADDR_WIDTH, 10: instruction address width.
- RESET_PC, 0: PC value loaded on reset.
- MEM_LAST, 150: highest valid instruction address. Any next-PC above it is a fault.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word read from memory at address pc (combinational return).
- branch_taken  input  1  ALU comparison result for the current beq/blt/bgt.
- jr_target  input  ADDR_WIDTH  register-file value of R31 for jr.
- continue_btn  input  1  asynchronous operator button, active-high.
- pc  output  ADDR_WIDTH  registered current instruction address, feeding the memory address input.
- exec_enable  output  1  current instruction may commit.
- link_write  output  1  write link_addr to R31 this cycle.
- link_addr  output  ADDR_WIDTH  pc+1.
- halted  output  1  state is HALTED.
- fault  output  1  state is FAULT.
- retired_count  output  32  number of instructions committed.

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-halt and mid-fault):
  - pc=RESET_PC, state=RUN, retired_count=0.
  - Both button synchroniser flops are set to 1, so a button held through reset produces no edge until it is released and pressed again.
- Opcode is instr[31:26]:
  - j=010111, jal=011010, jr=011011, halt=011101, beq=001001, blt=011100, bgt=011110.
  - All others are sequential.
- States: RUN, HALTED, FAULT.
- exec_enable = (state==RUN). Combinational from state; not gated by instr.
- Next-PC in RUN, evaluated each cycle:
  - j/jal: target = instr[ADDR_WIDTH-1:0]. If instr[25:ADDR_WIDTH] is nonzero, enter FAULT.
  - jr: target = jr_target.
  - beq/blt/bgt with branch_taken=1: target = instr[ADDR_WIDTH-1:0]. If instr[15:ADDR_WIDTH] is nonzero, enter FAULT.
  - Branch with branch_taken=0, and all other opcodes: pc+1, computed in ADDR_WIDTH+1 bits so wrap is detected rather than silent.
  - halt: pc <= pc+1, state <= HALTED.
  - If the selected target > MEM_LAST: state <= FAULT and pc is held at the offending instruction's address.
- Link:
  - link_addr = pc+1, truncated to ADDR_WIDTH.
  - link_write = exec_enable & (opcode==jal).
- HALTED:
  - pc held, pointing at the instruction after halt (normally `in`). exec_enable=0, link_write=0.
  - A rising edge on the synchronised continue_btn (2-flop sync + edge-detect register) sets state <= RUN on the following clock with pc unchanged, so the `in` then executes.
  - Minimum latency from button rise to exec_enable=1 is 3 clocks.
- RUN: continue edges are ignored and not remembered.
- FAULT: terminal until reset. pc held, exec_enable=0, fault=1. continue_btn is ignored.
- retired_count:
  - Increments by 1 on every clock with exec_enable=1, including the halt instruction itself and instructions causing FAULT.
  - Saturates at 32'hFFFFFFFF.
- Latency: pc changes exactly one clock after the instruction that determines it is presented. There are no bubbles in RUN.

Test Plan:
- Reset then 5 clocks of addi instructions (opcode 001011) -> pc=0,1,2,3,4,5. retired_count=5. exec_enable=1 throughout.
- pc=0, instr=j target 82 -> pc=82 next clock. At pc=82 a non-control instr -> 83. At 83 halt -> pc=84, halted=1, exec_enable=0. pc stays 84 for 20 clocks with the button low.
- From HALTED at pc=84: pulse continue_btn high 1 clock -> exec_enable=1 on the 3rd clock after the rise, pc still 84, then 85. Hold the button high 10 clocks -> only one resume. A second edge while in RUN has no effect.
- instr=jal target 27 at pc=107 -> link_write=1, link_addr=108, pc=27. Later jr with jr_target=108 -> pc=108.
- blt target 24 at pc=12: branch_taken=1 -> pc=24; branch_taken=0 -> pc=13. j target 200 -> fault=1, pc held at the jump's address, exec_enable=0, and continue_btn is ignored.
- Assert reset while HALTED, and separately while in FAULT, with continue_btn held high -> pc=0, state=RUN, no resume edge until the button is released and pressed again.
